// File: rtl/gray_counter_if.sv
// Handshake bundle between the Gray-code generator and its consumer.
//   en, up, load, load_bin : control from the requester to the counter
//   gray_out, out_valid    : presented Gray code and its valid flag
//   out_ready              : consumer can take gray_out this cycle
//   tc                     : one-cycle pulse after a terminal code is taken
// master = counter side, slave = requester/consumer side.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] gray_out;
  logic             out_valid;
  logic             out_ready;
  logic             tc;

  modport master (
    input  en, up, load, load_bin, out_ready,
    output gray_out, out_valid, tc
  );

  modport slave (
    output en, up, load, load_bin, out_ready,
    input  gray_out, out_valid, tc
  );
endinterface

// File: rtl/gray_counter.sv
// Registered Gray-code sequence generator with a valid/ready output.
// Steps a binary count up or down, emits its Gray encoding, supports a
// parallel binary load, and either wraps or saturates at the range ends.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : gray_counter_if master (control in, gray_out/out_valid/tc out)
// Parameters: WIDTH (2..16) code width, WRAP (1 = wrap, 0 = saturate).
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  gray_counter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SAT     = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] gray_q, gray_n;
  logic             tc_q, tc_n;

  logic             accept;
  logic             terminal;
  logic [WIDTH-1:0] step_val;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // In PRESENT, cnt is the code on the bus; terminal depends on the
  // direction sampled at the moment of acceptance.
  assign accept   = (state == PRESENT) && bus.out_ready;
  assign terminal = bus.up ? (cnt == '1) : (cnt == '0);
  assign step_val = bus.up ? (cnt + 1'b1) : (cnt - 1'b1);

  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gray_n  = gray_q;
    tc_n    = 1'b0;

    unique case (state)
      IDLE, SAT: begin
        // SAT ignores en/up; only a load (or reset) leaves it.
        if (bus.load) begin
          cnt_n   = bus.load_bin;
          gray_n  = to_gray(bus.load_bin);
          state_n = PRESENT;
        end else if (bus.en && (state == IDLE)) begin
          gray_n  = to_gray(cnt);
          state_n = PRESENT;
        end
      end

      PRESENT: begin
        // Without acceptance everything is frozen and load is dropped.
        if (accept) begin
          tc_n = terminal;
          if (terminal && (WRAP == 1'b0)) begin
            state_n = SAT;
          end else if (bus.load) begin
            cnt_n  = bus.load_bin;
            gray_n = to_gray(bus.load_bin);
          end else if (bus.en) begin
            cnt_n  = step_val;
            gray_n = to_gray(step_val);
          end else begin
            // Advance so that IDLE holds the next value to emit.
            cnt_n   = step_val;
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values; reset is synchronous, tested in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      gray_q <= gray_n;
      tc_q   <= tc_n;
    end
  end

  assign bus.gray_out  = gray_q;
  assign bus.out_valid = (state == PRESENT);
  assign bus.tc        = tc_q;

endmodule
